uriscv_mem_responder: RTL and testbench

Word-addressed memory responder that terminates the core's outbound tagged memory port: it accepts read/write requests with an 11-bit tag, performs them on an internal RAM, and returns one tagged, in-order acknowledgement per request after a fixed latency. It sits outside the TCM subsystem as the default backing store and peripheral-latency model, and it honours response back-pressure through a credit-limited response FIFO.

---
 rtl/uriscv_pkg.sv | 11 +
 rtl/uriscv_sync_fifo.sv | 44 ++++
 rtl/uriscv_mem_responder.sv | 115 +++++++++++
 tb/tb_uriscv_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uriscv_pkg.sv
// Shared types for the core's outbound tagged memory port.
package uriscv_pkg;

    localparam int TAG_W = 11;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } uriscv_mem_resp_t;

endpackage

// File: rtl/uriscv_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head data is read combinationally.
module uriscv_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uriscv_mem_responder.sv
// Tagged memory responder: RAM access on accept, fixed delay line, then a
// credit-limited response FIFO so responses never overflow under back-pressure.
module uriscv_mem_responder
    import uriscv_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_rd_i,
    input  logic [3:0]       mem_wr_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_data_wr_i,
    input  logic [TAG_W-1:0] mem_req_tag_i,
    output logic             mem_accept_o,
    output logic             mem_ack_o,
    output logic [31:0]      mem_data_rd_o,
    output logic [TAG_W-1:0] mem_resp_tag_o,
    input  logic             mem_resp_accept_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ram [DEPTH];
    logic [AW-1:0]    idx;
    logic             req;
    logic             acc;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    outstanding;
    uriscv_mem_resp_t req_resp;
    uriscv_mem_resp_t push_resp;
    uriscv_mem_resp_t head;
    logic             unused;

    assign unused       = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0], full};
    assign idx          = mem_addr_i[AW+1:2];
    assign req          = mem_rd_i | (|mem_wr_i);
    assign mem_accept_o = (outstanding < CW'(FIFO_DEPTH));
    assign acc          = req & mem_accept_o;
    assign pop          = mem_ack_o & mem_resp_accept_i;
    // The word captured here is the pre-write value, since the RAM updates on the same edge.
    assign req_resp     = '{tag: mem_req_tag_i, data: ram[idx]};

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int b = 0; b < 4; b++)
                if (mem_wr_i[b])
                    ram[idx][b*8 +: 8] <= mem_data_wr_i[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding <= '0;
        else if (acc && !pop)
            outstanding <= outstanding + 1'b1;
        else if (!acc && pop)
            outstanding <= outstanding - 1'b1;
    end

    generate
        if (LATENCY == 1) begin : g_nodly
            assign push      = acc;
            assign push_resp = req_resp;
        end else begin : g_dly
            logic [LATENCY-2:0] vld_pipe;
            uriscv_mem_resp_t   resp_pipe [LATENCY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= acc;
                    for (int i = 1; i < LATENCY-1; i++)
                        vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            always_ff @(posedge clk) begin
                resp_pipe[0] <= req_resp;
                for (int i = 1; i < LATENCY-1; i++)
                    resp_pipe[i] <= resp_pipe[i-1];
            end

            assign push      = vld_pipe[LATENCY-2];
            assign push_resp = resp_pipe[LATENCY-2];
        end
    endgenerate

    uriscv_sync_fifo #(
        .WIDTH ($bits(uriscv_mem_resp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_resp),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    // Gate the head so outputs read zero whenever no response is presented.
    assign mem_ack_o      = !empty;
    assign mem_data_rd_o  = mem_ack_o ? head.data : '0;
    assign mem_resp_tag_o = mem_ack_o ? head.tag  : '0;

endmodule

// File: tb/tb_uriscv_mem_responder.sv
// Bench for uriscv_mem_responder: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_uriscv_mem_responder;

    localparam int DEPTH      = 1024;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 0;
    logic        rst_n;
    logic        mem_rd_i;
    logic [3:0]  mem_wr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_wr_i;
    logic [10:0] mem_req_tag_i;
    logic        mem_accept_o;
    logic        mem_ack_o;
    logic [31:0] mem_data_rd_o;
    logic [10:0] mem_resp_tag_o;
    logic        mem_resp_accept_i;

    int checks = 0;
    int errors = 0;

    uriscv_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_rd_i          (mem_rd_i),
        .mem_wr_i          (mem_wr_i),
        .mem_addr_i        (mem_addr_i),
        .mem_data_wr_i     (mem_data_wr_i),
        .mem_req_tag_i     (mem_req_tag_i),
        .mem_accept_o      (mem_accept_o),
        .mem_ack_o         (mem_ack_o),
        .mem_data_rd_o     (mem_data_rd_o),
        .mem_resp_tag_o    (mem_resp_tag_o),
        .mem_resp_accept_i (mem_resp_accept_i)
    );

    always #5 clk = ~clk;

    // Reference model: word array with per-byte "known" flags and a queue of pending responses.
    typedef struct {
        int          ready;
        logic [10:0] tag;
        logic [31:0] data;
        bit          known;
    } ent_t;

    logic [31:0] mram   [DEPTH];
    bit   [3:0]  mknown [DEPTH];
    ent_t        mq[$];
    int          m_out  = 0;
    int          ecount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_out = 0;
        end else begin
            bit   m_ack, m_pop, m_acc;
            int   wi;
            ent_t e;
            m_ack = (mq.size() > 0) && (mq[0].ready <= ecount);
            m_pop = m_ack && mem_resp_accept_i;
            m_acc = (mem_rd_i || mem_wr_i != 4'h0) && (m_out < FIFO_DEPTH);
            ecount++;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                wi      = int'(mem_addr_i[11:2]);
                e.ready = ecount + LATENCY - 1;
                e.tag   = mem_req_tag_i;
                e.data  = mram[wi];
                e.known = &mknown[wi];
                for (int b = 0; b < 4; b++)
                    if (mem_wr_i[b]) begin
                        mram[wi][b*8 +: 8] = mem_data_wr_i[b*8 +: 8];
                        mknown[wi][b]      = 1'b1;
                    end
                mq.push_back(e);
            end
            m_out = m_out + int'(m_acc) - int'(m_pop);
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            bit exp_ack;
            exp_ack = (mq.size() > 0) && (mq[0].ready <= ecount);
            chk("model_accept", {31'd0, mem_accept_o}, {31'd0, m_out < FIFO_DEPTH});
            chk("model_ack", {31'd0, mem_ack_o}, {31'd0, exp_ack});
            if (exp_ack && mem_ack_o) begin
                chk("model_tag", {21'd0, mem_resp_tag_o}, {21'd0, mq[0].tag});
                if (mq[0].known)
                    chk("model_data", mem_data_rd_o, mq[0].data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit rd, input logic [3:0] wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [10:0] t);
        mem_rd_i      = rd;
        mem_wr_i      = wr;
        mem_addr_i    = a;
        mem_data_wr_i = d;
        mem_req_tag_i = t;
    endtask

    task automatic idle();
        req(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    endtask

    task automatic wait_tag(input logic [10:0] t, output logic [31:0] d);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (k > 0) cyc();
            if (mem_ack_o && mem_resp_tag_o == t) found = 1;
        end
        chk("wait_tag_found", {31'd0, found}, 32'd1);
        d = mem_data_rd_o;
    endtask

    initial begin
        logic [31:0] d;
        int          nacc;
        int          t;
        int          acks;
        rst_n = 0;
        mem_resp_accept_i = 1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("reset_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("reset_data", mem_data_rd_o, 32'd0);
        chk("reset_tag", {21'd0, mem_resp_tag_o}, 32'd0);
        chk("reset_accept", {31'd0, mem_accept_o}, 32'd1);

        // Write then read, exact latency.
        req(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 11'h005); cyc();
        req(1'b1, 4'h0, 32'h10, 32'h0, 11'h006);        cyc();
        idle();
        chk("wr_ack_t2", {31'd0, mem_ack_o}, 32'd1);
        chk("wr_tag", {21'd0, mem_resp_tag_o}, 32'h005);
        cyc();
        chk("rd_ack_t3", {31'd0, mem_ack_o}, 32'd1);
        chk("rd_tag", {21'd0, mem_resp_tag_o}, 32'h006);
        chk("rd_data", mem_data_rd_o, 32'hDEADBEEF);

        // Byte enables.
        req(1'b0, 4'hF, 32'h20, 32'h11223344, 11'h007); cyc();
        req(1'b0, 4'b0010, 32'h20, 32'h0000AA00, 11'h008); cyc();
        req(1'b1, 4'h0, 32'h20, 32'h0, 11'h009); cyc();
        idle();
        wait_tag(11'h009, d);
        chk("byte_en", d, 32'h1122AA44);

        // Simultaneous rd+wr is a write returning the old word.
        req(1'b0, 4'hF, 32'h40, 32'h0, 11'h00A); cyc();
        req(1'b1, 4'hF, 32'h40, 32'h5, 11'h00B); cyc();
        req(1'b1, 4'h0, 32'h40, 32'h0, 11'h00C); cyc();
        idle();
        wait_tag(11'h00B, d);
        chk("rdwr_old", d, 32'h0);
        wait_tag(11'h00C, d);
        chk("rdwr_new", d, 32'h5);

        // Aliasing above DEPTH.
        req(1'b0, 4'hF, 32'h1004, 32'hCAFE0001, 11'h00D); cyc();
        req(1'b1, 4'h0, 32'h0004, 32'h0, 11'h00E); cyc();
        idle();
        wait_tag(11'h00E, d);
        chk("alias", d, 32'hCAFE0001);
        repeat (6) cyc();

        // Back-pressure: six back-to-back attempts, only FIFO_DEPTH accepted.
        mem_resp_accept_i = 0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            req(1'b1, 4'h0, 32'h10, 32'h0, 11'(nacc));
            if (mem_accept_o) nacc++;
            cyc();
        end
        idle();
        chk("bp_accepted", nacc, 32'd4);
        chk("bp_accept_low", {31'd0, mem_accept_o}, 32'd0);
        chk("bp_head_tag0", {21'd0, mem_resp_tag_o}, 32'd0);
        mem_resp_accept_i = 1;
        cyc();
        mem_resp_accept_i = 0;
        chk("bp_slot_freed", {31'd0, mem_accept_o}, 32'd1);
        chk("bp_head_tag1", {21'd0, mem_resp_tag_o}, 32'd1);
        mem_resp_accept_i = 1;
        for (int i = 1; i < 4; i++) wait_tag(11'(i), d);
        for (t = 4; t < 6; t++) begin
            req(1'b1, 4'h0, 32'h10, 32'h0, 11'(t));
            cyc();
        end
        idle();
        wait_tag(11'd4, d);
        wait_tag(11'd5, d);
        chk("bp_data", d, 32'hDEADBEEF);
        repeat (6) cyc();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            int op;
            logic [3:0] m;
            op = $urandom_range(0, 3);
            m  = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) m = 4'hF;
            req(op == 1 || op == 3, (op >= 2) ? m : 4'h0,
                ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
                $urandom, 11'($urandom));
            mem_resp_accept_i = ($urandom_range(0, 9) < 7);
            cyc();
        end
        idle();
        mem_resp_accept_i = 1;
        repeat (12) cyc();
        chk("drain_ack", {31'd0, mem_ack_o}, 32'd0);

        // Reset with responses in flight.
        mem_resp_accept_i = 0;
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 4'h0, 32'h10, 32'h0, 11'(32'h30 + i));
            cyc();
        end
        idle();
        repeat (2) cyc();
        chk("pre_rst_ack", {31'd0, mem_ack_o}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_async_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("rst_tag", {21'd0, mem_resp_tag_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        mem_resp_accept_i = 1;
        chk("post_rst_accept", {31'd0, mem_accept_o}, 32'd1);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_ack_o) acks++;
            cyc();
        end
        chk("no_stale_acks", acks, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
